line_commit_queue: RTL and testbench
====================================

# line_commit_queue

Output buffer directly downstream of the compression pipeline's commit register. Each cycle it accepts the committed line pair and flag (zero, one or two 512-bit lines), queues the valid lines in order, and drains them one line per cycle over a valid/ready stream toward the memory/transmit side. The compression pipeline cannot stall, so the block never back-pressures upstream. Instead it drops whole groups that do not fit and counts the drops.

## Interface
Parameters:
- DEPTH, 16: queue capacity in 512-bit lines; power of two, >= 4.
- CNT_W, 16: width of the drop counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- lines_in  in  [1:0][511:0]  committed lines; [0] = first line, [1] = second line.
- flag_in  in  2  group descriptor:
  - 00: no lines.
  - 01: lines_in[0] only.
  - 10: lines_in[0] then lines_in[1].
  - 11: illegal.
- out_valid  out  1  head line available.
- out_ready  in  1  consumer accepts head this cycle.
- out_data  out  512  head line.
- out_last  out  1  head line is the final line of its group.
- occupancy  out  $clog2(DEPTH)+1  lines currently queued.
- overflow  out  1  sticky: a group has been dropped since reset.
- illegal_flag  out  1  sticky: flag_in == 11 seen since reset.
- drop_count  out  CNT_W  number of dropped groups; saturates at all-ones.

## Operation
- Storage: circular buffer of DEPTH entries, each {data[511:0], last}.
  - Write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count register: 0..DEPTH.
- Group size n:
  - flag 00 → n = 0.
  - flag 01 → n = 1.
  - flag 10 → n = 2.
  - flag 11 → n = 0. Nothing is written and illegal_flag sets; this does not count as a drop.
- Admission: a group is written only if n <= DEPTH - count, using count at the start of the cycle. A same-cycle pop gives no credit.
- Dropped groups: if n > free space, the whole group is dropped (never partially written). On a drop:
  - overflow sets.
  - drop_count increments unless already saturated.
- Write, n = 1: entry[wp] = {lines_in[0], 1}; wp += 1.
- Write, n = 2, both in the same cycle:
  - entry[wp] = {lines_in[0], 0}.
  - entry[wp+1] = {lines_in[1], 1}, with wrap.
  - wp += 2.
- Pop: occurs when out_valid && out_ready; rp += 1.
- Count update: count_next = count + written − popped. Simultaneous write and pop are legal in every state, including full (the pop is simply not credited for admission).
- Outputs:
  - out_valid = (count != 0).
  - out_data / out_last = entry[rp] (show-ahead).
  - occupancy = count.
- Stream rules:
  - Once out_valid is high with a given head, out_data and out_last hold until the pop.
  - out_ready is ignored while out_valid is low.
- Reset (rst == 0 at a rising edge):
  - wp = rp = count = 0.
  - overflow = illegal_flag = 0; drop_count = 0.
  - out_valid = 0, out_last = 0, occupancy = 0.
  - out_data is don't-care while out_valid = 0.
  - Reset mid-drain discards all queued lines. Input during the reset cycle is ignored.

## Timing
- Write latency: a group presented in cycle N is visible at the head (if the queue was empty) with out_valid = 1 in cycle N+1. There is no combinational path from lines_in or flag_in to any output.
- Throughput: 1 line per cycle out; up to 2 lines per cycle in. A sustained input of 2 lines per cycle overflows after DEPTH/2 + k cycles, where k depends on drain.
- Pop at cycle N:
  - The next entry is at the head in cycle N+1.
  - occupancy reflects the pop in N+1.
- out_ready → out_valid: no combinational path; out_valid depends only on count.
- Status timing: overflow, illegal_flag and drop_count update in the cycle after the offending input.

## Test plan
- Reset/idle:
  - Hold rst = 0 for 3 cycles with flag_in = 10 → out_valid = 0, occupancy = 0, drop_count = 0.
  - Release rst, flag_in = 00 for 5 cycles → outputs unchanged.
- Ordering and last bit:
  - Push 01 (A), then 10 (B, C), then 01 (D), with out_ready = 1 → lines out A, B, C, D on consecutive cycles starting the cycle after A.
  - out_last = 1, 0, 1, 1.
- Full and drop (DEPTH = 16, out_ready = 0):
  - Eight 10 groups → occupancy = 16.
  - Push one 01 group → dropped; overflow = 1, drop_count = 1, occupancy = 16.
  - Then raise out_ready → the 16 original lines drain intact.
- Partial-fit rejection:
  - With occupancy = 15, out_ready = 1 and a simultaneous pop, push 10 → group dropped (no pop credit); drop_count increments; occupancy = 14 next cycle.
  - With occupancy = 15, push 01 → accepted; occupancy = 16 (or 15 with a concurrent pop).
- Wrap-around and backpressure:
  - Random out_ready (50%) and random flags 00/01/10 for 2000 cycles.
  - Scoreboard checks exact order, last bits, data held stable while stalled, and occupancy = model at every cycle.
  - Pointers wrap at least 50 times.
- Illegal flag, saturation and mid-stream reset:
  - flag_in = 11 → illegal_flag = 1, no write, drop_count unchanged.
  - With CNT_W = 4, force 20 drops → drop_count = 15.
  - Assert rst with 6 lines queued → next cycle occupancy = 0, out_valid = 0, sticky flags clear.

Source files
------------

// File: rtl/line_commit_queue.sv
// Output queue behind the compression commit register: accepts 0/1/2 lines per cycle,
// drains one line per cycle on a valid/ready stream, drops whole groups that do not fit.
module line_commit_queue #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0][511:0]        lines_in,
  input  logic [1:0]               flag_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [511:0]             out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow,
  output logic                     illegal_flag,
  output logic [CNT_W-1:0]         drop_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [511:0]     data_mem [DEPTH];
  logic             last_mem [DEPTH];
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [OW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [1:0]       grp_n;
  logic [OW-1:0]    free_lines;
  logic             wr_en, pop;

  always_comb begin
    grp_n = 2'd0;
    case (flag_in)
      2'b01:   grp_n = 2'd1;
      2'b10:   grp_n = 2'd2;
      default: grp_n = 2'd0;
    endcase
    // Admission sees only the count at the start of the cycle; a concurrent pop earns no credit.
    free_lines = DEPTH_C - count_q;
    wr_en      = (grp_n != 2'd0) && (OW'(grp_n) <= free_lines);
    pop        = (count_q != '0) && out_ready;
    wp_d       = wr_en ? wp_q + PW'(grp_n) : wp_q;
    rp_d       = pop ? rp_q + PW'(1) : rp_q;
    count_d    = count_q + (wr_en ? OW'(grp_n) : '0) - OW'(pop);
    overflow_d = overflow_q;
    drop_d     = drop_q;
    illegal_d  = illegal_q;
    if ((grp_n != 2'd0) && !wr_en) begin
      overflow_d = 1'b1;
      drop_d     = sat_inc(drop_q);
    end
    if (flag_in == 2'b11) illegal_d = 1'b1;
  end

  // Line storage carries no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      data_mem[wp_q] <= lines_in[0];
      last_mem[wp_q] <= (grp_n == 2'd1);
      if (grp_n == 2'd2) begin
        data_mem[wp_q + PW'(1)] <= lines_in[1];
        last_mem[wp_q + PW'(1)] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
      drop_q     <= drop_d;
    end
  end

  assign out_valid    = (count_q != '0);
  assign out_data     = data_mem[rp_q];
  assign out_last     = out_valid & last_mem[rp_q];
  assign occupancy    = count_q;
  assign overflow     = overflow_q;
  assign illegal_flag = illegal_q;
  assign drop_count   = drop_q;
endmodule

// File: tb/tb_line_commit_queue.sv
// Scoreboard bench for line_commit_queue: expected lines queued on admission, compared on pop.
module tb_line_commit_queue;
  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0][511:0]      lines_in;
  logic [1:0]             flag_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [511:0]           out_data;
  logic                   out_last;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   overflow;
  logic                   illegal_flag;
  logic [CNT_W-1:0]       drop_count;

  line_commit_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .lines_in(lines_in), .flag_in(flag_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .occupancy(occupancy), .overflow(overflow),
    .illegal_flag(illegal_flag), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [512:0] sb[$];
  logic m_over, m_ill;
  int m_drop;
  int uid = 1;

  function automatic logic [511:0] mk(input int id);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = 32'(id) * 32'h9E37_79B9 + 32'(k) * 32'h0101_0101;
    return r;
  endfunction

  function automatic logic [511:0] rnd();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // One cycle: drive inputs, retire the model head on a pop, apply admission, advance the clock.
  task automatic tick(input logic [1:0] f, input logic [511:0] a, input logic [511:0] b, input logic rdy);
    int n;
    int sz;
    logic [512:0] exp_e;
    flag_in = f; lines_in[0] = a; lines_in[1] = b; out_ready = rdy;
    sz = sb.size();
    n_cmp++;
    if (out_valid !== (sz != 0)) begin
      n_fail++;
      $display("FAIL sb_valid: out_valid=%b expected %b", out_valid, (sz != 0));
    end
    if (sz != 0 && rdy) begin
      exp_e = sb.pop_front();
      n_cmp++;
      if ({out_data, out_last} !== exp_e) begin
        n_fail++;
        $display("FAIL sb_pop: data=%h last=%b expected data=%h last=%b", out_data, out_last, exp_e[512:1], exp_e[0]);
      end
    end
    n = (f == 2'b01) ? 1 : (f == 2'b10) ? 2 : 0;
    if (f == 2'b11) m_ill = 1'b1;
    if (n != 0) begin
      if (n <= DEPTH - sz) begin
        if (n == 1) sb.push_back({a, 1'b1});
        else begin
          sb.push_back({a, 1'b0});
          sb.push_back({b, 1'b1});
        end
      end else begin
        m_over = 1'b1;
        if (m_drop != DROP_MAX) m_drop++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b0; flag_in = 2'b10; lines_in[0] = mk(999); lines_in[1] = mk(998); out_ready = 1'b1;
    repeat (ncyc) begin
      @(posedge clk);
      @(negedge clk);
    end
    sb.delete(); m_over = 1'b0; m_ill = 1'b0; m_drop = 0;
    rst = 1'b1; flag_in = 2'b00;
  endtask

  task automatic test_reset();
    do_reset(3);
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== '0 || drop_count !== '0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b occ=%0d drop=%0d last=%b expected 0/0/0/0", out_valid, occupancy, drop_count, out_last);
    end
    repeat (5) tick(2'b00, '0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== '0 || overflow !== 1'b0 || illegal_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_state: valid=%b occ=%0d ovf=%b ill=%b expected all 0", out_valid, occupancy, overflow, illegal_flag);
    end
  endtask

  task automatic test_order();
    logic [511:0] la, lb, lc, ld;
    la = mk(uid); lb = mk(uid + 1); lc = mk(uid + 2); ld = mk(uid + 3); uid += 4;
    tick(2'b01, la, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== la || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL order_first: valid=%b last=%b head_ok=%b expected valid=1 last=1 head=A", out_valid, out_last, out_data === la);
    end
    tick(2'b10, lb, lc, 1'b1);
    n_cmp++;
    if (occupancy !== 5'd2 || out_data !== lb || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL order_b: occ=%0d last=%b expected occ=2 last=0", occupancy, out_last);
    end
    tick(2'b01, ld, '0, 1'b1);
    n_cmp++;
    if (occupancy !== 5'd2 || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL order_c: occ=%0d last=%b expected occ=2 last=1", occupancy, out_last);
    end
    tick(2'b00, '0, '0, 1'b1);
    tick(2'b00, '0, '0, 1'b1);
    n_cmp++;
    if (occupancy !== 5'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL order_drain: occ=%0d model=%0d expected 0/0", occupancy, sb.size());
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      tick(2'b10, mk(uid), mk(uid + 1), 1'b0);
      uid += 2;
    end
    n_cmp++;
    if (occupancy !== 5'd16) begin
      n_fail++;
      $display("FAIL full_occ: occ=%0d expected 16", occupancy);
    end
    tick(2'b01, mk(uid), '0, 1'b0); uid++;
    n_cmp++;
    if (overflow !== 1'b1 || drop_count !== CNT_W'(m_drop) || occupancy !== 5'd16) begin
      n_fail++;
      $display("FAIL full_drop: ovf=%b drop=%0d occ=%0d expected 1/%0d/16", overflow, drop_count, occupancy, m_drop);
    end
    for (int i = 0; i < 16; i++) tick(2'b00, '0, '0, 1'b1);
    n_cmp++;
    if (occupancy !== 5'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL full_drain: occ=%0d model=%0d expected 0", occupancy, sb.size());
    end
  endtask

  task automatic test_partial();
    for (int i = 0; i < 7; i++) begin
      tick(2'b10, mk(uid), mk(uid + 1), 1'b0);
      uid += 2;
    end
    tick(2'b01, mk(uid), '0, 1'b0); uid++;
    n_cmp++;
    if (occupancy !== 5'd15) begin
      n_fail++;
      $display("FAIL partial_occ15: occ=%0d expected 15", occupancy);
    end
    tick(2'b10, mk(uid), mk(uid + 1), 1'b1); uid += 2;
    n_cmp++;
    if (occupancy !== 5'd14 || drop_count !== CNT_W'(m_drop) || m_drop != 2) begin
      n_fail++;
      $display("FAIL partial_nocredit: occ=%0d drop=%0d expected occ=14 drop=2", occupancy, drop_count);
    end
    tick(2'b01, mk(uid), '0, 1'b0); uid++;
    tick(2'b01, mk(uid), '0, 1'b0); uid++;
    n_cmp++;
    if (occupancy !== 5'd16 || drop_count !== CNT_W'(m_drop)) begin
      n_fail++;
      $display("FAIL partial_fit1: occ=%0d drop=%0d expected occ=16 drop=%0d", occupancy, drop_count, m_drop);
    end
    for (int i = 0; i < 16; i++) tick(2'b00, '0, '0, 1'b1);
  endtask

  task automatic test_illegal();
    tick(2'b11, mk(uid), mk(uid + 1), 1'b0); uid += 2;
    n_cmp++;
    if (illegal_flag !== 1'b1 || occupancy !== 5'd0 || out_valid !== 1'b0 || drop_count !== CNT_W'(m_drop)) begin
      n_fail++;
      $display("FAIL illegal: ill=%b occ=%0d valid=%b drop=%0d expected 1/0/0/%0d", illegal_flag, occupancy, out_valid, drop_count, m_drop);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8; i++) begin
      tick(2'b10, mk(uid), mk(uid + 1), 1'b0);
      uid += 2;
    end
    for (int i = 0; i < 20; i++) begin
      tick(2'b01, mk(uid), '0, 1'b0); uid++;
      n_cmp++;
      if (drop_count !== CNT_W'(m_drop)) begin
        n_fail++;
        $display("FAIL sat_step%0d: drop=%0d expected %0d", i, drop_count, m_drop);
      end
    end
    n_cmp++;
    if (drop_count !== 4'd15 || occupancy !== 5'd16) begin
      n_fail++;
      $display("FAIL sat_final: drop=%0d occ=%0d expected 15/16", drop_count, occupancy);
    end
    for (int i = 0; i < 16; i++) tick(2'b00, '0, '0, 1'b1);
  endtask

  task automatic test_random();
    logic [1:0] f;
    logic rdy;
    do_reset(1);
    for (int c = 0; c < 2000; c++) begin
      n_cmp++;
      if (occupancy !== 5'(sb.size())) begin
        n_fail++;
        $display("FAIL rnd_occ cycle %0d: occ=%0d expected %0d", c, occupancy, sb.size());
      end
      if (sb.size() != 0) begin
        n_cmp++;
        if ({out_data, out_last} !== sb[0]) begin
          n_fail++;
          $display("FAIL rnd_head cycle %0d: last=%b expected last=%b data_ok=%b", c, out_last, sb[0][0], out_data === sb[0][512:1]);
        end
      end
      f = 2'($urandom_range(0, 2));
      rdy = 1'($urandom_range(0, 1));
      tick(f, rnd(), rnd(), rdy);
    end
    n_cmp++;
    if (overflow !== m_over || drop_count !== CNT_W'(m_drop)) begin
      n_fail++;
      $display("FAIL rnd_status: ovf=%b drop=%0d expected %b/%0d", overflow, drop_count, m_over, m_drop);
    end
    for (int i = 0; i < 20; i++) tick(2'b00, '0, '0, 1'b1);
  endtask

  task automatic test_midreset();
    do_reset(1);
    tick(2'b11, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(2'b10, mk(uid), mk(uid + 1), 1'b0);
      uid += 2;
    end
    n_cmp++;
    if (occupancy !== 5'd6 || illegal_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: occ=%0d ill=%b expected 6/1", occupancy, illegal_flag);
    end
    do_reset(1);
    n_cmp++;
    if (occupancy !== 5'd0 || out_valid !== 1'b0 || illegal_flag !== 1'b0 || overflow !== 1'b0 || drop_count !== '0) begin
      n_fail++;
      $display("FAIL midrst_post: occ=%0d valid=%b ill=%b ovf=%b drop=%0d expected all 0", occupancy, out_valid, illegal_flag, overflow, drop_count);
    end
    tick(2'b00, '0, '0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; flag_in = 2'b00; lines_in = '0; out_ready = 1'b0;
    m_over = 1'b0; m_ill = 1'b0; m_drop = 0;
    @(negedge clk);
    test_reset();
    test_order();
    test_full();
    test_partial();
    test_illegal();
    test_saturation();
    test_random();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
